mem_ctrl: RTL and testbench
===========================

Name: mem_ctrl

Overview:
Initiator-side memory controller that drives the unified 32-bit instruction/data RAM (rd_en/wr_en/addr/din in, dout out, RAM acts on negedge clk). It arbitrates between a read-only instruction-fetch port and a read/write data port. Each accepted request becomes exactly one RAM strobe cycle and one response. Out-of-range addresses are rejected before they reach the RAM.

Parameters:
ADDR_W, 16, request and RAM address width
DATA_W, 32, data width
MEM_DEPTH, 512, number of valid words; addr >= MEM_DEPTH is an error
STARVE_LIMIT, 4, consecutive data grants allowed while fetch waits

Ports:
clk  in  1  system clock, rising-edge logic
rst_n  in  1  reset; one clock, reset is synchronous and active-low
if_req_valid  in  1  fetch request valid
if_req_ready  out  1  fetch request accepted this cycle
if_addr  in  ADDR_W  fetch word address
if_resp_valid  out  1  fetch response, one-cycle pulse
if_rdata  out  DATA_W  fetch read data
if_resp_err  out  1  fetch address out of range
d_req_valid  in  1  data request valid
d_req_ready  out  1  data request accepted this cycle
d_we  in  1  1 = write, 0 = read
d_addr  in  ADDR_W  data word address
d_wdata  in  DATA_W  write data
d_resp_valid  out  1  data response or write ack, one-cycle pulse
d_rdata  out  DATA_W  data read data; 0 for writes and errors
d_resp_err  out  1  data address out of range
mem_rd_en  out  1  RAM read strobe
mem_wr_en  out  1  RAM write strobe
mem_addr  out  ADDR_W  RAM address
mem_din  out  DATA_W  RAM write data
mem_dout  in  DATA_W  RAM read data; valid after the negedge of the strobe cycle

Behaviour:
- FSM states: IDLE, ACCESS, RESP. On reset: IDLE, starve_cnt=0, all registered outputs 0.
- Ready signals:
  - Both readies are 0 outside IDLE.
  - In IDLE, a ready is the combinational grant. At most one grant per cycle.
- Grant rule:
  - Only one valid: that port is granted.
  - Both valid: data port wins, unless starve_cnt == STARVE_LIMIT, in which case fetch wins.
- starve_cnt:
  - Increments on each data grant while if_req_valid=1.
  - Clears on a fetch grant, and whenever if_req_valid=0 in IDLE.
  - Saturates at STARVE_LIMIT.
- Accept at posedge T:
  - Latch port id, we, addr and wdata.
  - In-range request: go to ACCESS.
  - Out-of-range request (addr >= MEM_DEPTH): go directly to RESP with err=1 and rdata=0. No RAM strobe is ever driven.
- ACCESS (cycle T+1):
  - Registered mem_addr/mem_din are driven.
  - Exactly one of mem_rd_en or mem_wr_en is 1, for exactly this one cycle. Both are never 1 together.
  - The RAM acts on this cycle's negedge.
  - At posedge T+2, capture mem_dout for reads and go to RESP.
- RESP (cycle T+2):
  - The owning port's resp_valid=1 for one cycle, with rdata (read) or 0 (write ack) and the err flag.
  - The other port's response outputs stay 0.
  - Next state is IDLE.
- Latency: accept to resp_valid is 2 cycles (in-range and error alike). Peak throughput is one request per 3 cycles.
- Responses have no backpressure; requesters must consume the pulse.
- rdata outputs hold their last value between responses; only resp_valid qualifies them.
- Requesters hold valid/addr/we/wdata stable until ready. The controller samples inputs only on the accept edge.
- mem_addr and mem_din hold their last value when idle; strobes are 0.
- Reset mid-operation: rst_n low at posedge returns to IDLE and zeroes outputs/strobes from that edge. An in-flight request is dropped with no response.
  - A strobe already driven in the ACCESS cycle completes at that cycle's negedge. This is accepted.

Decomposition:
- Package mem_ctrl_pkg holds:
  - State encoding (IDLE=0, ACCESS=1, RESP=2).
  - Port-id constants (PORT_IF=0, PORT_D=1).
  - MEM_DEPTH default.
- Sub-module mem_ctrl_arb: combinational grant plus the starve_cnt register, with inputs if_valid, d_valid and idle, and outputs grant_if and grant_d.
- The FSM and datapath registers stay in mem_ctrl.

Test Plan:
1. RAM word 0 = 0x09000002; fetch if_addr=0x0000 accepted at T -> mem_rd_en=1 only in T+1, mem_addr=0; if_resp_valid=1 at T+2 with if_rdata=0x09000002, if_resp_err=0.
2. Data write d_addr=0x0010, d_wdata=0xDEADBEEF, then data read 0x0010 -> mem_wr_en one cycle with mem_din=0xDEADBEEF and mem_rd_en=0; write ack d_rdata=0; read returns d_rdata=0xDEADBEEF.
3. Data read d_addr=0x0200 -> no mem_rd_en or mem_wr_en ever; d_resp_valid at T+2 with d_resp_err=1, d_rdata=0.
4. Both ports valid continuously -> grant order is D,D,D,D,IF,D,D,D,D,IF...; accepts spaced exactly 3 cycles apart; rd_en and wr_en never both 1.
5. Single fetch valid while the FSM is busy -> if_req_ready=0 during ACCESS and RESP; the request is accepted in the next IDLE cycle and its address is taken at that accept edge.
6. rst_n=0 for one edge during ACCESS of a read -> next cycle state IDLE and all outputs 0, no resp_valid; a following fetch of 0x0001 completes normally.

Source files
------------

// File: rtl/mem_ctrl_pkg.sv
// Shared encodings and defaults for the unified-RAM memory controller.
package mem_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  typedef enum logic {
    PORT_IF = 1'b0,
    PORT_D  = 1'b1
  } port_t;

  localparam int unsigned MEM_DEPTH_DEF = 512;

endpackage

// File: rtl/mem_ctrl_arb.sv
// Fetch/data arbiter: data port has priority until fetch has waited
// STARVE_LIMIT consecutive data grants.
module mem_ctrl_arb #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic if_valid,
  input  logic d_valid,
  input  logic idle,
  output logic grant_if,
  output logic grant_d
);

  localparam int unsigned CW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);

  logic [CW-1:0] starve_q, starve_d;
  logic          starved;

  assign starved = (32'(starve_q) == STARVE_LIMIT);

  always_comb begin
    grant_d  = idle & d_valid & ~(if_valid & starved);
    grant_if = idle & if_valid & (~d_valid | starved);
    starve_d = starve_q;
    if (idle) begin
      if (!if_valid || grant_if) begin
        starve_d = '0;
      end else if (grant_d && !starved) begin
        starve_d = starve_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      starve_q <= '0;
    end else begin
      starve_q <= starve_d;
    end
  end

endmodule

// File: rtl/mem_ctrl.sv
// Memory controller: arbitrates fetch and data requests onto a single
// negedge-acting RAM, one strobe cycle and one response pulse per request.
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W       = 16,
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned MEM_DEPTH    = MEM_DEPTH_DEF,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req_valid,
  output logic              if_req_ready,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_resp_valid,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_resp_err,
  input  logic              d_req_valid,
  output logic              d_req_ready,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_resp_valid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_resp_err,
  output logic              mem_rd_en,
  output logic              mem_wr_en,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_din,
  input  logic [DATA_W-1:0] mem_dout
);

  state_t            state_q;
  port_t             port_q;
  logic              we_q;
  logic              err_hold_q;
  logic              mem_rd_en_q, mem_wr_en_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_din_q;
  logic              if_resp_valid_q, if_resp_err_q;
  logic [DATA_W-1:0] if_rdata_q;
  logic              d_resp_valid_q, d_resp_err_q;
  logic [DATA_W-1:0] d_rdata_q;

  logic              grant_if, grant_d;
  logic              acc_we, acc_ok;
  logic [ADDR_W-1:0] acc_addr;

  mem_ctrl_arb #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .if_valid(if_req_valid),
    .d_valid (d_req_valid),
    .idle    (state_q == IDLE),
    .grant_if(grant_if),
    .grant_d (grant_d)
  );

  assign acc_we   = grant_d & d_we;
  assign acc_addr = grant_d ? d_addr : if_addr;
  assign acc_ok   = (32'(acc_addr) < MEM_DEPTH);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q         <= IDLE;
      port_q          <= PORT_IF;
      we_q            <= 1'b0;
      err_hold_q      <= 1'b0;
      mem_rd_en_q     <= 1'b0;
      mem_wr_en_q     <= 1'b0;
      mem_addr_q      <= '0;
      mem_din_q       <= '0;
      if_resp_valid_q <= 1'b0;
      if_resp_err_q   <= 1'b0;
      if_rdata_q      <= '0;
      d_resp_valid_q  <= 1'b0;
      d_resp_err_q    <= 1'b0;
      d_rdata_q       <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (grant_if || grant_d) begin
            port_q <= grant_d ? PORT_D : PORT_IF;
            we_q   <= acc_we;
            if (acc_ok) begin
              state_q     <= ACCESS;
              mem_addr_q  <= acc_addr;
              mem_rd_en_q <= ~acc_we;
              mem_wr_en_q <= acc_we;
              if (acc_we) begin
                mem_din_q <= d_wdata;
              end
            end else begin
              // Error path waits one RESP cycle so it keeps the in-range latency.
              state_q    <= RESP;
              err_hold_q <= 1'b1;
            end
          end
        end
        ACCESS: begin
          state_q     <= RESP;
          mem_rd_en_q <= 1'b0;
          mem_wr_en_q <= 1'b0;
          if (port_q == PORT_D) begin
            d_resp_valid_q <= 1'b1;
            d_resp_err_q   <= 1'b0;
            d_rdata_q      <= we_q ? '0 : mem_dout;
          end else begin
            if_resp_valid_q <= 1'b1;
            if_resp_err_q   <= 1'b0;
            if_rdata_q      <= mem_dout;
          end
        end
        RESP: begin
          if (err_hold_q) begin
            err_hold_q <= 1'b0;
            if (port_q == PORT_D) begin
              d_resp_valid_q <= 1'b1;
              d_resp_err_q   <= 1'b1;
              d_rdata_q      <= '0;
            end else begin
              if_resp_valid_q <= 1'b1;
              if_resp_err_q   <= 1'b1;
              if_rdata_q      <= '0;
            end
          end else begin
            state_q         <= IDLE;
            if_resp_valid_q <= 1'b0;
            if_resp_err_q   <= 1'b0;
            d_resp_valid_q  <= 1'b0;
            d_resp_err_q    <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign if_req_ready  = grant_if;
  assign d_req_ready   = grant_d;
  assign if_resp_valid = if_resp_valid_q;
  assign if_rdata      = if_rdata_q;
  assign if_resp_err   = if_resp_err_q;
  assign d_resp_valid  = d_resp_valid_q;
  assign d_rdata       = d_rdata_q;
  assign d_resp_err    = d_resp_err_q;
  assign mem_rd_en     = mem_rd_en_q;
  assign mem_wr_en     = mem_wr_en_q;
  assign mem_addr      = mem_addr_q;
  assign mem_din       = mem_din_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed bench for mem_ctrl with a negedge-acting RAM model.
module tb_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_req_valid, if_req_ready;
  logic [15:0] if_addr;
  logic        if_resp_valid, if_resp_err;
  logic [31:0] if_rdata;
  logic        d_req_valid, d_req_ready, d_we;
  logic [15:0] d_addr;
  logic [31:0] d_wdata, d_rdata;
  logic        d_resp_valid, d_resp_err;
  logic        mem_rd_en, mem_wr_en;
  logic [15:0] mem_addr;
  logic [31:0] mem_din, mem_dout;

  logic [31:0] ram [0:511];

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mem_ctrl #(
    .ADDR_W(16), .DATA_W(32), .MEM_DEPTH(512), .STARVE_LIMIT(4)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req_valid(if_req_valid), .if_req_ready(if_req_ready), .if_addr(if_addr),
    .if_resp_valid(if_resp_valid), .if_rdata(if_rdata), .if_resp_err(if_resp_err),
    .d_req_valid(d_req_valid), .d_req_ready(d_req_ready), .d_we(d_we),
    .d_addr(d_addr), .d_wdata(d_wdata),
    .d_resp_valid(d_resp_valid), .d_rdata(d_rdata), .d_resp_err(d_resp_err),
    .mem_rd_en(mem_rd_en), .mem_wr_en(mem_wr_en), .mem_addr(mem_addr),
    .mem_din(mem_din), .mem_dout(mem_dout)
  );

  always @(negedge clk) begin
    if (mem_wr_en && mem_addr < 16'd512) ram[mem_addr[8:0]] <= mem_din;
    if (mem_rd_en && mem_addr < 16'd512) mem_dout <= ram[mem_addr[8:0]];
  end

  typedef struct {
    logic        is_d;
    logic        we;
    logic [15:0] addr;
    logic [31:0] wdata;
    logic        exp_rd;
    logic        exp_wr;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vecs [10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_if_ready"}, 32'(if_req_ready), 0);
    chk({tag, "_d_ready"}, 32'(d_req_ready), 0);
    chk({tag, "_if_rv"}, 32'(if_resp_valid), 0);
    chk({tag, "_if_rdata"}, if_rdata, 0);
    chk({tag, "_if_err"}, 32'(if_resp_err), 0);
    chk({tag, "_d_rv"}, 32'(d_resp_valid), 0);
    chk({tag, "_d_rdata"}, d_rdata, 0);
    chk({tag, "_d_err"}, 32'(d_resp_err), 0);
    chk({tag, "_rd_en"}, 32'(mem_rd_en), 0);
    chk({tag, "_wr_en"}, 32'(mem_wr_en), 0);
    chk({tag, "_mem_addr"}, 32'(mem_addr), 0);
    chk({tag, "_mem_din"}, mem_din, 0);
  endtask

  task automatic do_req(input vec_t v, input int idx);
    int    n;
    string t;
    logic  rdy;
    t = $sformatf("v%0d", idx);
    @(negedge clk);
    if (v.is_d) begin
      d_req_valid = 1'b1; d_we = v.we; d_addr = v.addr; d_wdata = v.wdata;
    end else begin
      if_req_valid = 1'b1; if_addr = v.addr;
    end
    #1;
    n = 0;
    rdy = v.is_d ? d_req_ready : if_req_ready;
    while (!rdy && n < 20) begin
      @(negedge clk); #1;
      n++;
      rdy = v.is_d ? d_req_ready : if_req_ready;
    end
    chk({t, "_accept"}, 32'(rdy), 1);
    @(posedge clk); #1;
    d_req_valid = 1'b0; if_req_valid = 1'b0;
    d_addr = 16'h7777; if_addr = 16'h7777; d_wdata = 32'h5555_AAAA; d_we = 1'b0;
    if (!rdy) return;
    @(negedge clk);
    chk({t, "_rd_en"}, 32'(mem_rd_en), 32'(v.exp_rd));
    chk({t, "_wr_en"}, 32'(mem_wr_en), 32'(v.exp_wr));
    if (v.exp_rd || v.exp_wr) chk({t, "_mem_addr"}, 32'(mem_addr), 32'(v.addr));
    if (v.exp_wr) chk({t, "_mem_din"}, mem_din, v.wdata);
    chk({t, "_early_rv"}, 32'(if_resp_valid | d_resp_valid), 0);
    @(negedge clk);
    chk({t, "_t2_strobes"}, 32'(mem_rd_en | mem_wr_en), 0);
    if (v.is_d) begin
      chk({t, "_d_rv"}, 32'(d_resp_valid), 1);
      chk({t, "_d_rdata"}, d_rdata, v.exp_rdata);
      chk({t, "_d_err"}, 32'(d_resp_err), 32'(v.exp_err));
      chk({t, "_if_rv"}, 32'(if_resp_valid | if_resp_err), 0);
    end else begin
      chk({t, "_if_rv"}, 32'(if_resp_valid), 1);
      chk({t, "_if_rdata"}, if_rdata, v.exp_rdata);
      chk({t, "_if_err"}, 32'(if_resp_err), 32'(v.exp_err));
      chk({t, "_d_rv"}, 32'(d_resp_valid | d_resp_err), 0);
    end
    @(negedge clk);
    chk({t, "_pulse_end"}, 32'(if_resp_valid | d_resp_valid), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int g, last;
    bit done;

    for (int unsigned i = 0; i < 512; i++) ram[i] <= 32'h0;
    #0;
    ram[0]     <= 32'h0900_0002;
    ram[1]     <= 32'h1111_0001;
    ram[2]     <= 32'h2222_0002;
    ram[3]     <= 32'h3333_0003;
    ram[4]     <= 32'h4444_0004;
    ram[9'h1FF] <= 32'hA5A5_0001;

    //          is_d we  addr      wdata         rd wr exp_rdata     err
    vecs[0] = '{1'b0, 1'b0, 16'h0000, 32'h0,        1, 0, 32'h0900_0002, 0};
    vecs[1] = '{1'b1, 1'b1, 16'h0010, 32'hDEAD_BEEF, 0, 1, 32'h0,         0};
    vecs[2] = '{1'b1, 1'b0, 16'h0010, 32'h0,        1, 0, 32'hDEAD_BEEF, 0};
    vecs[3] = '{1'b1, 1'b0, 16'h0200, 32'h0,        0, 0, 32'h0,         1};
    vecs[4] = '{1'b0, 1'b0, 16'h01FF, 32'h0,        1, 0, 32'hA5A5_0001, 0};
    vecs[5] = '{1'b0, 1'b0, 16'hFFFF, 32'h0,        0, 0, 32'h0,         1};
    vecs[6] = '{1'b1, 1'b1, 16'h01FF, 32'h1234_5678, 0, 1, 32'h0,         0};
    vecs[7] = '{1'b0, 1'b0, 16'h01FF, 32'h0,        1, 0, 32'h1234_5678, 0};
    vecs[8] = '{1'b1, 1'b1, 16'h0200, 32'hCAFE_F00D, 0, 0, 32'h0,         1};
    vecs[9] = '{1'b1, 1'b0, 16'h01FF, 32'h0,        1, 0, 32'h1234_5678, 0};

    rst_n = 1'b0;
    if_req_valid = 1'b0; if_addr = '0;
    d_req_valid = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_all_zero("rst");
    @(posedge clk); #1;
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++) do_req(vecs[i], i);

    // Both ports valid continuously: D,D,D,D,IF repeating, 3 cycles apart.
    g = 0; last = 0; done = 1'b0;
    @(negedge clk);
    if_req_valid = 1'b1; if_addr = 16'h0001;
    d_req_valid = 1'b1; d_we = 1'b0; d_addr = 16'h0002;
    for (int cyc = 0; cyc < 60 && !done; cyc++) begin
      #1;
      chk("s4_excl", 32'(mem_rd_en & mem_wr_en), 0);
      if (if_resp_valid) chk("s4_if_rdata", if_rdata, 32'h1111_0001);
      if (d_resp_valid) chk("s4_d_rdata", d_rdata, 32'h2222_0002);
      if (if_req_ready || d_req_ready) begin
        chk("s4_one_grant", 32'(if_req_ready & d_req_ready), 0);
        chk($sformatf("s4_grant%0d_is_d", g), 32'(d_req_ready), 32'((g % 5) != 4));
        if (g > 0) chk("s4_spacing", 32'(cyc - last), 3);
        last = cyc;
        g++;
        if (g == 10) begin
          @(posedge clk); #1;
          if_req_valid = 1'b0; d_req_valid = 1'b0;
          done = 1'b1;
        end
      end
      if (!done) @(negedge clk);
    end
    chk("s4_grant_count", 32'(g), 10);
    if (!done) begin
      if_req_valid = 1'b0; d_req_valid = 1'b0;
    end
    repeat (3) @(negedge clk);

    // Fetch waits while busy; its address is taken at the accept edge.
    @(negedge clk);
    d_req_valid = 1'b1; d_we = 1'b0; d_addr = 16'h0004;
    #1;
    chk("s5_d_ready", 32'(d_req_ready), 1);
    @(posedge clk); #1;
    d_req_valid = 1'b0;
    if_req_valid = 1'b1; if_addr = 16'h0005;
    @(negedge clk);
    chk("s5_if_ready_access", 32'(if_req_ready), 0);
    @(posedge clk); #1;
    if_addr = 16'h0003;
    @(negedge clk);
    chk("s5_if_ready_resp", 32'(if_req_ready), 0);
    chk("s5_d_rv", 32'(d_resp_valid), 1);
    chk("s5_d_rdata", d_rdata, 32'h4444_0004);
    @(negedge clk);
    chk("s5_if_ready_idle", 32'(if_req_ready), 1);
    @(posedge clk); #1;
    if_req_valid = 1'b0;
    @(negedge clk);
    chk("s5_rd_en", 32'(mem_rd_en), 1);
    chk("s5_mem_addr", 32'(mem_addr), 32'h3);
    @(negedge clk);
    chk("s5_if_rv", 32'(if_resp_valid), 1);
    chk("s5_if_rdata", if_rdata, 32'h3333_0003);

    // Reset during ACCESS drops the read with no response.
    @(negedge clk);
    if_req_valid = 1'b1; if_addr = 16'h0002;
    #1;
    chk("s6_if_ready", 32'(if_req_ready), 1);
    @(posedge clk); #1;
    if_req_valid = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    chk("s6_rd_en_before_rst", 32'(mem_rd_en), 1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk_all_zero("s6_post_rst");
    @(negedge clk);
    chk("s6_no_resp", 32'(if_resp_valid | d_resp_valid), 0);
    do_req('{1'b0, 1'b0, 16'h0001, 32'h0, 1, 0, 32'h1111_0001, 0}, 10);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
